mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
//  Sits between the PC/IFID/EXMEM pipeline and the memory.
//  Serialises accesses with a req/ack handshake, one access outstanding at a time.
//  Stalls whichever stage is waiting for the memory.
//  Data accesses have priority; a streak limit bounds instruction-fetch starvation.
// PARAMETERS
//  ADDR_W        32  address width, byte address
//  DATA_W        32  data width
//  STARVE_LIMIT  4   max consecutive DM grants while if_req_i is pending; then IF wins the next grant (range 1..15)
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       synchronous, active-low reset
//  start_i      in   1       run enable; low = no new grants (an access in flight still completes)
//  if_req_i     in   1       fetch request, held until if_valid_o
//  if_addr_i    in   ADDR_W  fetch address (PC)
//  if_rdata_o   out  DATA_W  fetched instruction, valid with if_valid_o
//  if_valid_o   out  1       one-cycle pulse: fetch data ready
//  if_stall_o   out  1       freeze PC and IFID
//  dm_req_i     in   1       data request (EXMEM MemRead|MemWrite), held until dm_valid_o
//  dm_we_i      in   1       1 = store, 0 = load
//  dm_addr_i    in   ADDR_W  data address (EXMEM ALU result)
//  dm_wdata_i   in   DATA_W  store data
//  dm_rdata_o   out  DATA_W  load data, valid with dm_valid_o
//  dm_valid_o   out  1       one-cycle pulse: data access complete (load or store)
//  dm_stall_o   out  1       freeze the whole pipeline up to EXMEM
//  mem_req_o    out  1       memory request, held high until mem_ack_i
//  mem_we_o     out  1       memory write enable
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_rdata_i  in   DATA_W  memory read data, valid with mem_ack_i
//  mem_ack_i    in   1       memory completes the access this cycle (latency >= 1 cycle)
// BEHAVIOUR
//  Reset (rst_i == 0 at a clock edge):
//   - state = IDLE; streak = 0.
//   - All outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, both rdata, both valid.
//   - Stall outputs are combinational and follow the rules below.
//   - Reset mid-access aborts it: no valid pulse is produced, and a later mem_ack_i in IDLE is ignored.
//  FSM states: IDLE, BUSY_IF, BUSY_DM.
//  Eligibility: a requester is eligible when its req_i is 1, its valid_o is 0, and it is not being acked this cycle.
//   - This prevents a stale re-grant of the same address.
//  Arbitration (IDLE, or BUSY_x with mem_ack_i == 1), only when start_i == 1:
//   - DM eligible and (streak < STARVE_LIMIT or IF not eligible) -> grant DM.
//   - Otherwise, IF eligible -> grant IF.
//   - Otherwise -> IDLE.
//  Grant:
//   - Register addr/we/wdata into the mem_* outputs.
//   - mem_req_o = 1 from the next cycle on; go to BUSY_x.
//   - mem_we_o = 0 for IF grants.
//  BUSY_x:
//   - mem_* outputs stay constant until mem_ack_i.
//   - On ack: register mem_rdata_i into x_rdata_o and pulse x_valid_o = 1 in the next cycle.
//   - Then re-arbitrate in the same cycle (back-to-back issue allowed); mem_req_o drops only if nothing is granted.
//  x_rdata_o holds its value until the next ack for that requester.
//  Streak counter (4 bits):
//   - DM grant while if_req_i == 1: +1, saturating at STARVE_LIMIT.
//   - Any IF grant, or if_req_i == 0: cleared to 0.
//  Stalls (combinational):
//   - if_stall_o = if_req_i & ~if_valid_o.
//   - dm_stall_o = dm_req_i & ~dm_valid_o.
//  start_i low during BUSY_x: the access still completes and valid still pulses; no further grants.
//  Simultaneous IF+DM requests from IDLE: DM first, IF next; the IF stall lasts two accesses.
// STRUCTURE
//  Shared package (cpu_pkg):
//   - FSM state encoding ARB_IDLE=2'd0, ARB_IF=2'd1, ARB_DM=2'd2.
//   - Grant-owner constants.
//  Single module; the streak counter is inline, no sub-module.
//  Flat always blocks:
//   - one sequential block (state, mem_* regs, rdata/valid regs, streak);
//   - one combinational block (next state / grant select);
//   - assign statements for the stalls.
// TESTING
//  1. Reset mid-access:
//     - Stimulus: reset with if_req_i=1; release; memory ack latency 2.
//     - Required: mem_req_o=1, mem_addr_o=if_addr_i, mem_we_o=0 at cycle 1; if_valid_o pulses at cycle 4 with the data.
//     - Required: drive rst_i=0 mid-BUSY -> all outputs 0 next cycle, no valid pulse, late ack ignored.
//  2. Simultaneous requests from IDLE:
//     - Stimulus: IF @0x40 and DM store @0x100, data 0xDEADBEEF.
//     - Required: DM issued first (mem_we_o=1, addr 0x100), then IF @0x40.
//     - Required: dm_valid_o pulses before if_valid_o; if_stall_o stays 1 throughout.
//  3. Starvation bound:
//     - Stimulus: STARVE_LIMIT=4; dm_req_i with a new address each grant, if_req_i held.
//     - Required: exactly 4 DM grants, then an IF grant, then DM resumes.
//  4. Back-to-back:
//     - Stimulus: memory ack latency 1, continuous IF requests.
//     - Required: mem_req_o never drops between grants.
//     - Required: same-address re-grant never occurs (one mem access per if_valid_o pulse).
//  5. start_i low:
//     - Stimulus: start_i low during BUSY_DM.
//     - Required: the access completes and dm_valid_o pulses; no new mem_req_o until start_i returns high.
//  6. Load data path:
//     - Stimulus: DM load @0x200, mem_rdata_i=0x12345678.
//     - Required: dm_rdata_o=0x12345678 with dm_valid_o; value held afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM encoding and grant owners.
package cpu_pkg;

    typedef logic [1:0] arb_state_t;
    typedef logic [1:0] owner_t;

    // Arbiter FSM encoding
    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_IF   = 2'd1;
    localparam arb_state_t ARB_DM   = 2'd2;

    // Who receives the grant decided this cycle
    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_IF   = 2'd1;
    localparam owner_t OWN_DM   = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// One access outstanding at a time; data accesses win unless IF has been passed over
// STARVE_LIMIT times in a row.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no access outstanding, mem_req_o low
// ARB_IF   | fetch access outstanding, waiting for mem_ack_i
// ARB_DM   | load/store access outstanding, waiting for mem_ack_i
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam logic [3:0] STREAK_LIM = 4'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    owner_t            grant_sel;
    logic [3:0]        streak_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              if_valid_q, dm_valid_q;

    logic if_acked, dm_acked;
    logic if_elig, dm_elig;
    logic arb_slot;
    logic streak_ok;

    // An acked requester still holds its old request this cycle and next; masking it
    // out keeps the same address from being issued twice.
    assign if_acked  = (state_q == ARB_IF) && mem_ack_i;
    assign dm_acked  = (state_q == ARB_DM) && mem_ack_i;
    assign if_elig   = if_req_i && !if_valid_q && !if_acked;
    assign dm_elig   = dm_req_i && !dm_valid_q && !dm_acked;
    assign streak_ok = (streak_q < STREAK_LIM);

    // Arbitration happens when the port is free or frees up this cycle; a stray ack
    // while idle is not an access completion.
    assign arb_slot = (state_q != ARB_IF && state_q != ARB_DM) || mem_ack_i;

    // Next state and grant selection
    always_comb begin
        state_d   = state_q;
        grant_sel = OWN_NONE;
        if (arb_slot) begin
            state_d = ARB_IDLE;
            if (start_i) begin
                if (dm_elig && (streak_ok || !if_elig)) begin
                    grant_sel = OWN_DM;
                    state_d   = ARB_DM;
                end else if (if_elig) begin
                    grant_sel = OWN_IF;
                    state_d   = ARB_IF;
                end
            end
        end
    end

    // State, memory-side registers, returned data, valid pulses and starvation streak
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ARB_IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_acked;
            dm_valid_q <= dm_acked;
            if (if_acked) begin
                if_rdata_q <= mem_rdata_i;
            end
            if (dm_acked) begin
                dm_rdata_q <= mem_rdata_i;
            end

            case (grant_sel)
                OWN_DM: begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= dm_we_i;
                    mem_addr_q  <= dm_addr_i;
                    mem_wdata_q <= dm_wdata_i;
                end
                OWN_IF: begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= if_addr_i;
                    mem_wdata_q <= '0;
                end
                default: begin
                    if (if_acked || dm_acked) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
            endcase

            if (!if_req_i || grant_sel == OWN_IF) begin
                streak_q <= '0;
            end else if (grant_sel == OWN_DM && streak_ok) begin
                streak_q <= streak_q + 4'd1;
            end
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign dm_valid_o  = dm_valid_q;

    assign if_stall_o = if_req_i & ~if_valid_q;
    assign dm_stall_o = dm_req_i & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run, with a
// transaction-level memory/requester model and an access log.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_i, start_i;
    logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_valid_o, if_stall_o, dm_valid_o, dm_stall_o, mem_req_o, mem_we_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
        .dm_stall_o(dm_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    typedef struct {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    acc_t if_q[$], dm_q[$], log_q[$], exp_q[$];
    acc_t last_acc;
    logic [31:0] memm [logic [31:0]];

    int   lat = 2;
    bit   rand_lat = 0;
    int   mcnt = 0;
    bit   force_ack = 0;
    bit   gate_mode = 0;
    int   gate_cnt = 0;
    bit   prev_ack_live = 0;
    bit   prev_req = 0;
    logic prev_we = 0;
    logic [31:0] prev_addr = 0, prev_wdata = 0, last_rdata = 0;
    int   if_pulses = 0, dm_pulses = 0, if_pulse_cyc = 0, dm_pulse_cyc = 0;
    int   dm_run = 0, max_dm_run = 0;
    int   hi_cnt = 0, first_hi = -1, last_hi = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic acc_t mk(input logic dm, input logic we, input logic [31:0] a,
                                input logic [31:0] d);
        acc_t t;
        t.dm = dm; t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (memm.exists(a)) return memm[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic drive_agents();
        if (if_q.size() > 0) begin
            if_req_i  = 1'b1;
            if_addr_i = if_q[0].addr;
        end else begin
            if_req_i = 1'b0;
        end
        if (dm_q.size() > 0) begin
            dm_req_i   = 1'b1;
            dm_we_i    = dm_q[0].we;
            dm_addr_i  = dm_q[0].addr;
            dm_wdata_i = dm_q[0].wdata;
        end else begin
            dm_req_i = 1'b0;
        end
    endtask

    // One clock: check outputs, play the memory, then update requesters.
    task automatic step();
        bit   rst_s, start_s, exp_v, issue;
        acc_t cur;
        @(posedge clk);
        rst_s   = rst_i;
        start_s = start_i;
        #1;
        cyc++;

        exp_v = prev_ack_live && rst_s;
        chk("valid_count", 64'(if_valid_o) + 64'(dm_valid_o), 64'(exp_v));
        chk("if_stall", if_stall_o, if_req_i & ~if_valid_o);
        chk("dm_stall", dm_stall_o, dm_req_i & ~dm_valid_o);
        if (!rst_s)
            chk("reset_outputs_zero", |{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                if_rdata_o, dm_rdata_o, if_valid_o, dm_valid_o}, 0);

        if (if_valid_o) begin
            if_pulses++;
            if_pulse_cyc = cyc;
            chk("if_rdata", if_rdata_o, last_rdata);
            chk("if_valid_has_request", 64'(if_q.size() > 0), 1);
            if (if_q.size() > 0)
                chk("if_owner", {last_acc.dm, last_acc.we, last_acc.addr},
                    {1'b0, 1'b0, if_q[0].addr});
        end
        if (dm_valid_o) begin
            dm_pulses++;
            dm_pulse_cyc = cyc;
            chk("dm_rdata", dm_rdata_o, last_rdata);
            chk("dm_valid_has_request", 64'(dm_q.size() > 0), 1);
            if (dm_q.size() > 0) begin
                chk("dm_owner", {last_acc.dm, last_acc.we, last_acc.addr},
                    {1'b1, dm_q[0].we, dm_q[0].addr});
                if (dm_q[0].we) chk("dm_store_wdata", last_acc.wdata, dm_q[0].wdata);
            end
        end

        cur = mk(dm_req_i && mem_addr_o == dm_addr_i && mem_we_o == dm_we_i &&
                 (!mem_we_o || mem_wdata_o == dm_wdata_i), mem_we_o, mem_addr_o, mem_wdata_o);
        issue = mem_req_o && (!prev_req || prev_ack_live);
        if (mem_req_o && prev_req && !prev_ack_live)
            chk("mem_stable", {prev_we, prev_addr, prev_wdata}, {mem_we_o, mem_addr_o, mem_wdata_o});
        if (mem_req_o) begin
            hi_cnt++;
            if (first_hi < 0) first_hi = cyc;
            last_hi = cyc;
        end
        if (issue) begin
            chk("grant_needs_start", start_s, 1);
            log_q.push_back(cur);
            mcnt = 0;
            if (rand_lat) lat = int'($urandom_range(1, 3));
            if (cur.dm) begin
                if (if_req_i) dm_run++;
                else dm_run = 0;
                if (dm_run > max_dm_run) max_dm_run = dm_run;
            end else begin
                dm_run = 0;
            end
        end

        mem_ack_i = 1'b0;
        if (force_ack) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hBAD0_BAD0;
        end else if (mem_req_o) begin
            mcnt++;
            if (mcnt == lat + 1) begin
                mem_ack_i = 1'b1;
                if (mem_we_o) begin
                    memm[mem_addr_o] = mem_wdata_o;
                    mem_rdata_i = ~mem_wdata_o;
                end else begin
                    mem_rdata_i = rd(mem_addr_o);
                end
                last_rdata = mem_rdata_i;
                last_acc   = cur;
            end
        end
        prev_ack_live = mem_ack_i && mem_req_o;
        prev_req   = mem_req_o;
        prev_we    = mem_we_o;
        prev_addr  = mem_addr_o;
        prev_wdata = mem_wdata_o;

        if (gate_mode) begin
            if (mem_ack_i) gate_cnt = 2;
            start_i = (gate_cnt == 0);
            if (gate_cnt > 0) gate_cnt--;
        end

        if (if_valid_o && if_q.size() > 0) void'(if_q.pop_front());
        if (dm_valid_o && dm_q.size() > 0) void'(dm_q.pop_front());
        drive_agents();
    endtask

    task automatic run_done(input string tag, input int maxc);
        int n = 0;
        while ((if_q.size() > 0 || dm_q.size() > 0 || mem_req_o) && n < maxc) begin
            step();
            n++;
        end
        chk({tag, "_finished_in_budget"}, 64'(n < maxc), 1);
        step();
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_access_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_access%0d", tag, i), {log_q[i].dm, log_q[i].we, log_q[i].addr},
                {exp_q[i].dm, exp_q[i].we, exp_q[i].addr});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, base_if, base_dm, if_pushed, dm_pushed, stall_low;

        rst_i = 1'b0; start_i = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;

        // Scenario 1: fetch out of reset, then abort an access with reset
        lat = 2;
        if_q.push_back(mk(0, 0, 32'h0000_1000, 0));
        drive_agents();
        repeat (3) step();
        rst_i = 1'b1;
        t0 = cyc;
        step();
        chk("t1_req_c1", mem_req_o, 1);
        chk("t1_addr_c1", mem_addr_o, 32'h0000_1000);
        chk("t1_we_c1", mem_we_o, 0);
        step();
        step();
        step();
        chk("t1_if_valid_c4", if_valid_o, 1);
        chk("t1_if_valid_cycle", cyc - t0, 4);
        chk("t1_if_rdata_c4", if_rdata_o, rd(32'h0000_1000));
        if_q.push_back(mk(0, 0, 32'h0000_1004, 0));
        drive_agents();
        n = 0;
        while (!mem_req_o && n < 10) begin
            step();
            n++;
        end
        chk("t1_second_issue_seen", mem_req_o, 1);
        step();
        rst_i = 1'b0;
        if_q.delete();
        drive_agents();
        step();
        chk("t1_abort_req", mem_req_o, 0);
        chk("t1_abort_rdata", if_rdata_o, 0);
        rst_i = 1'b1;
        force_ack = 1'b1;
        step();
        step();
        force_ack = 1'b0;
        step();
        chk("t1_late_ack_no_valid", if_pulses, 1);
        chk("t1_late_ack_no_req", mem_req_o, 0);

        // Scenario 2: simultaneous store and fetch from idle
        log_q.delete();
        lat = 2;
        dm_q.push_back(mk(1, 1, 32'h0000_0100, 32'hDEAD_BEEF));
        if_q.push_back(mk(0, 0, 32'h0000_0040, 0));
        drive_agents();
        stall_low = 0;
        n = 0;
        while (!if_valid_o && n < 40) begin
            step();
            if (!if_valid_o && !if_stall_o) stall_low++;
            n++;
        end
        chk("t2_if_stall_held", stall_low, 0);
        run_done("t2", 20);
        exp_q.delete();
        exp_q.push_back(mk(1, 1, 32'h0000_0100, 0));
        exp_q.push_back(mk(0, 0, 32'h0000_0040, 0));
        check_log("t2");
        if (log_q.size() > 0) chk("t2_store_wdata", log_q[0].wdata, 32'hDEAD_BEEF);
        chk("t2_dm_before_if", 64'(dm_pulse_cyc < if_pulse_cyc), 1);

        // Scenario 3: starvation bound, start_i pulsed low around every ack
        log_q.delete();
        lat = 1;
        max_dm_run = 0;
        dm_run = 0;
        gate_mode = 1;
        for (int i = 0; i < 6; i++) dm_q.push_back(mk(1, 1, 32'h0000_0300 + 32'(4 * i), 32'(i + 7)));
        if_q.push_back(mk(0, 0, 32'h0000_0500, 0));
        if_q.push_back(mk(0, 0, 32'h0000_0504, 0));
        drive_agents();
        run_done("t3", 200);
        gate_mode = 0;
        start_i = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 1, 32'h0000_0300 + 32'(4 * i), 0));
        exp_q.push_back(mk(0, 0, 32'h0000_0500, 0));
        exp_q.push_back(mk(1, 1, 32'h0000_0310, 0));
        exp_q.push_back(mk(1, 1, 32'h0000_0314, 0));
        exp_q.push_back(mk(0, 0, 32'h0000_0504, 0));
        check_log("t3");
        chk("t3_max_dm_streak", max_dm_run, LIM);

        // Scenario 4: back-to-back issue with latency 1, both streams busy
        log_q.delete();
        lat = 1;
        hi_cnt = 0; first_hi = -1; last_hi = -1;
        base_if = if_pulses;
        for (int i = 0; i < 5; i++) begin
            dm_q.push_back(mk(1, 0, 32'h8000_0000 + 32'(4 * i), 0));
            if_q.push_back(mk(0, 0, 32'h0000_0600 + 32'(4 * i), 0));
        end
        drive_agents();
        run_done("t4", 100);
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(1, 0, 32'h8000_0000 + 32'(4 * i), 0));
            exp_q.push_back(mk(0, 0, 32'h0000_0600 + 32'(4 * i), 0));
        end
        check_log("t4");
        chk("t4_req_high_cycles", hi_cnt, 20);
        chk("t4_req_contiguous", last_hi - first_hi + 1, hi_cnt);
        chk("t4_one_access_per_if_valid", if_pulses - base_if, 5);

        // Scenario 5: start_i low while a load is in flight
        log_q.delete();
        lat = 3;
        base_dm = dm_pulses;
        dm_q.push_back(mk(1, 0, 32'h8000_0700, 0));
        drive_agents();
        n = 0;
        while (!mem_req_o && n < 10) begin
            step();
            n++;
        end
        start_i = 1'b0;
        if_q.push_back(mk(0, 0, 32'h0000_0700, 0));
        drive_agents();
        repeat (10) step();
        chk("t5_dm_valid_while_stopped", dm_pulses - base_dm, 1);
        chk("t5_no_new_grant", log_q.size(), 1);
        chk("t5_req_low", mem_req_o, 0);
        start_i = 1'b1;
        run_done("t5", 40);
        chk("t5_resume_count", log_q.size(), 2);
        if (log_q.size() > 1)
            chk("t5_resume_is_if", {log_q[1].dm, log_q[1].addr}, {1'b0, 32'h0000_0700});

        // Scenario 6: load data path and hold
        lat = 2;
        memm[32'h0000_0200] = 32'h1234_5678;
        dm_q.push_back(mk(1, 0, 32'h0000_0200, 0));
        drive_agents();
        n = 0;
        while (!dm_valid_o && n < 20) begin
            step();
            n++;
        end
        chk("t6_dm_valid", dm_valid_o, 1);
        chk("t6_load_data", dm_rdata_o, 32'h1234_5678);
        if_q.push_back(mk(0, 0, 32'h0000_0800, 0));
        drive_agents();
        run_done("t6", 40);
        chk("t6_load_data_held", dm_rdata_o, 32'h1234_5678);

        // Randomized traffic with random latency and start_i dropouts
        rand_lat = 1;
        max_dm_run = 0;
        dm_run = 0;
        base_if = if_pulses;
        base_dm = dm_pulses;
        if_pushed = 0;
        dm_pushed = 0;
        for (int k = 0; k < 1500; k++) begin
            if (if_q.size() < 2 && $urandom_range(0, 3) == 0) begin
                if_q.push_back(mk(0, 0, 32'h0000_1000 + 32'(4 * $urandom_range(0, 255)), 0));
                if_pushed++;
            end
            if (dm_q.size() < 2 && $urandom_range(0, 2) == 0) begin
                dm_q.push_back(mk(1, 1'($urandom_range(0, 1)),
                                  32'h8000_0000 + 32'(4 * $urandom_range(0, 63)), $urandom));
                dm_pushed++;
            end
            start_i = ($urandom_range(0, 7) != 0);
            drive_agents();
            step();
        end
        start_i = 1'b1;
        run_done("rand", 400);
        chk("rand_if_completions", if_pulses - base_if, if_pushed);
        chk("rand_dm_completions", dm_pulses - base_dm, dm_pushed);
        chk("rand_streak_bound", 64'(max_dm_run <= LIM), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
